reg_file_mp: RTL and testbench

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/rv32im_pkg.sv | 10 +
 rtl/reg_scoreboard.sv | 50 +++++
 rtl/reg_file_mp.sv | 91 +++++++++
 tb/tb_reg_file_mp.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32im_pkg.sv
// Shared register-file constants and port-slice helpers.
package rv32im_pkg;
  localparam int XLEN   = 32;  // default register width
  localparam int REG_AW = 5;   // default address width (32 registers)

  // Low bit of slice p when a bus packs fields of width w side by side.
  function automatic int slice_lo(input int p, input int w);
    return p * w;
  endfunction
endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard with a registered population count.
module reg_scoreboard #(
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_WR     = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_WR-1:0]                    wr_en,
  input  logic [NUM_WR-1:0][ADDR_WIDTH-1:0]    wr_addr,
  input  logic                                 rsv_en,
  input  logic [ADDR_WIDTH-1:0]                rsv_addr,
  input  logic                                 flush,
  output logic [(1<<ADDR_WIDTH)-1:0]           busy,
  output logic [ADDR_WIDTH:0]                  busy_cnt
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0]  busy_nxt;
  logic [ADDR_WIDTH:0] cnt_nxt;

  // Next busy vector: writes retire, a reserve re-arms (it belongs to a
  // younger producer), flush wipes everything, r0 never becomes busy.
  always_comb begin
    busy_nxt = busy;
    for (int k = 0; k < NUM_WR; k++)
      if (wr_en[k]) busy_nxt[wr_addr[k]] = 1'b0;
    if (rsv_en) busy_nxt[rsv_addr] = 1'b1;
    if (flush) busy_nxt = '0;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  // Population count of the next vector so the registered count tracks busy.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++)
      cnt_nxt = cnt_nxt + (ADDR_WIDTH+1)'(busy_nxt[i]);
  end

  // Scoreboard state and count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end
endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with write-through bypass and busy scoreboard.
module reg_file_mp
  import rv32im_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_WIDTH = REG_AW,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] RD_ADDR,
  output logic [NUM_RD*DATA_WIDTH-1:0] RD_DATA,
  output logic [NUM_RD-1:0]            RD_BUSY,
  input  logic [NUM_WR-1:0]            WR_EN,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] WR_ADDR,
  input  logic [NUM_WR*DATA_WIDTH-1:0] WR_DATA,
  input  logic                         RSV_EN,
  input  logic [ADDR_WIDTH-1:0]        RSV_ADDR,
  input  logic                         FLUSH,
  output logic [ADDR_WIDTH:0]          BUSY_CNT
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0][DATA_WIDTH-1:0]  mem;
  logic [DEPTH-1:0]                  busy;
  logic [NUM_WR-1:0][ADDR_WIDTH-1:0] wa;
  logic [NUM_WR-1:0][DATA_WIDTH-1:0] wd;
  logic [NUM_WR-1:0]                 wv;  // write that actually lands

  for (genvar k = 0; k < NUM_WR; k++) begin : g_wr
    assign wa[k] = WR_ADDR[slice_lo(k, ADDR_WIDTH) +: ADDR_WIDTH];
    assign wd[k] = WR_DATA[slice_lo(k, DATA_WIDTH) +: DATA_WIDTH];
    assign wv[k] = WR_EN[k] && !((ZERO_REG != 0) && (wa[k] == '0));
  end

  // Commit writes; ports are visited low to high so the highest index wins.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mem <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++)
        if (wv[k]) mem[wa[k]] <= wd[k];
    end
  end

  reg_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_WR     (NUM_WR),
    .ZERO_REG   (ZERO_REG)
  ) u_sb (
    .clk      (CLK),
    .rst_n    (RESET),
    .wr_en    (wv),
    .wr_addr  (wa),
    .rsv_en   (RSV_EN),
    .rsv_addr (RSV_ADDR),
    .flush    (FLUSH),
    .busy     (busy),
    .busy_cnt (BUSY_CNT)
  );

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] d;
    logic                  b;

    assign ra = RD_ADDR[slice_lo(p, ADDR_WIDTH) +: ADDR_WIDTH];

    // Array read with bypass from the highest-index matching write; a
    // same-cycle write retires the producer so the busy flag drops.
    always_comb begin
      d = mem[ra];
      b = busy[ra];
      for (int k = 0; k < NUM_WR; k++) begin
        if (WR_EN[k] && (wa[k] == ra)) begin
          d = wd[k];
          b = 1'b0;
        end
      end
      if (((ZERO_REG != 0) && (ra == '0)) || !RESET) begin
        d = '0;
        b = 1'b0;
      end
    end

    assign RD_DATA[slice_lo(p, DATA_WIDTH) +: DATA_WIDTH] = d;
    assign RD_BUSY[p] = b;
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed table, random vs model, resets.
module tb_reg_file_mp;
  logic        CLK = 1'b0;
  logic        RESET;
  logic [9:0]  RD_ADDR;
  logic [63:0] RD_DATA;
  logic [1:0]  RD_BUSY;
  logic [1:0]  WR_EN;
  logic [9:0]  WR_ADDR;
  logic [63:0] WR_DATA;
  logic        RSV_EN;
  logic [4:0]  RSV_ADDR;
  logic        FLUSH;
  logic [5:0]  BUSY_CNT;

  int errors = 0;
  int checks = 0;

  // Reference model: plain register contents and busy flags.
  logic [31:0] m_mem [32];
  bit          m_busy[32];

  reg_file_mp dut (
    .CLK(CLK), .RESET(RESET), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA),
    .RD_BUSY(RD_BUSY), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .RSV_EN(RSV_EN), .RSV_ADDR(RSV_ADDR), .FLUSH(FLUSH), .BUSY_CNT(BUSY_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       nm;
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [4:0]  ra0, ra1;
    logic        rsv;
    logic [4:0]  rsva;
    logic        fl;
    logic [31:0] e_rd0, e_rd1;
    logic [1:0]  e_bsy;
    logic [5:0]  e_cnt;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic int model_cnt();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  // What the rules say an edge does with the currently driven inputs.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int a = int'(WR_ADDR[k*5 +: 5]);
      if (WR_EN[k] && a != 0) begin
        m_mem[a]  = WR_DATA[k*32 +: 32];
        m_busy[a] = 1'b0;
      end
    end
    if (FLUSH) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else if (RSV_EN && RSV_ADDR != 0) begin
      m_busy[RSV_ADDR] = 1'b1;
    end
  endtask

  // Expected combinational read outputs from the model plus live writes.
  task automatic check_reads(input string tag);
    for (int p = 0; p < 2; p++) begin
      int a = int'(RD_ADDR[p*5 +: 5]);
      logic [31:0] ed;
      logic        eb;
      int best = -1;
      for (int k = 1; k >= 0; k--)
        if (best < 0 && WR_EN[k] && int'(WR_ADDR[k*5 +: 5]) == a) best = k;
      if (a == 0) begin
        ed = '0; eb = 1'b0;
      end else if (best >= 0) begin
        ed = WR_DATA[best*32 +: 32]; eb = 1'b0;
      end else begin
        ed = m_mem[a]; eb = m_busy[a];
      end
      chk($sformatf("%s_rd%0d", tag, p), RD_DATA[p*32 +: 32], ed);
      chk($sformatf("%s_busy%0d", tag, p), {31'd0, RD_BUSY[p]}, {31'd0, eb});
    end
  endtask

  task automatic idle();
    WR_EN = '0; WR_ADDR = '0; WR_DATA = '0;
    RSV_EN = 1'b0; RSV_ADDR = '0; FLUSH = 1'b0;
  endtask

  vec_t tbl[$];

  initial begin
    model_reset();
    idle();
    RESET = 1'b0;
    RD_ADDR = {5'd31, 5'd5};

    // Reset state, with a write and reserve presented that must be dropped.
    WR_EN = 2'b01; WR_ADDR = {5'd0, 5'd5}; WR_DATA = {32'd0, 32'hFFFF_FFFF};
    RSV_EN = 1'b1; RSV_ADDR = 5'd5;
    #12;
    chk("rst_rd0", RD_DATA[31:0], 32'd0);
    chk("rst_rd1", RD_DATA[63:32], 32'd0);
    chk("rst_busy", {30'd0, RD_BUSY}, 32'd0);
    chk("rst_cnt", {26'd0, BUSY_CNT}, 32'd0);
    @(posedge CLK); #1;
    idle();
    RESET = 1'b1;
    #1;
    chk("rel_rd0", RD_DATA[31:0], 32'd0);
    chk("rel_rd1", RD_DATA[63:32], 32'd0);
    chk("rel_busy", {30'd0, RD_BUSY}, 32'd0);
    @(posedge CLK); #1;
    chk("rel_cnt", {26'd0, BUSY_CNT}, 32'd0);
    chk("rel_x5", RD_DATA[31:0], 32'd0);

    // Directed table: conflict/bypass, zero register, scoreboard, flush.
    tbl.push_back('{"conflict",  2'b11, 5'd7, 5'd7, 32'h1111_1111, 32'h2222_2222, 5'd7, 5'd31, 1'b0, 5'd0,  1'b0, 32'h2222_2222, 32'd0,         2'b00, 6'd0});
    tbl.push_back('{"confl_nxt", 2'b00, 5'd0, 5'd0, 32'd0, 32'd0,                 5'd7, 5'd7,  1'b0, 5'd0,  1'b0, 32'h2222_2222, 32'h2222_2222, 2'b00, 6'd0});
    tbl.push_back('{"zero_wr",   2'b01, 5'd0, 5'd0, 32'hDEAD_BEEF, 32'd0,         5'd0, 5'd7,  1'b1, 5'd0,  1'b0, 32'd0,         32'h2222_2222, 2'b00, 6'd0});
    tbl.push_back('{"zero_nxt",  2'b00, 5'd0, 5'd0, 32'd0, 32'd0,                 5'd0, 5'd31, 1'b0, 5'd0,  1'b0, 32'd0,         32'd0,         2'b00, 6'd0});
    tbl.push_back('{"rsv3",      2'b00, 5'd0, 5'd0, 32'd0, 32'd0,                 5'd3, 5'd4,  1'b1, 5'd3,  1'b0, 32'd0,         32'd0,         2'b00, 6'd1});
    tbl.push_back('{"rsv4",      2'b00, 5'd0, 5'd0, 32'd0, 32'd0,                 5'd3, 5'd4,  1'b1, 5'd4,  1'b0, 32'd0,         32'd0,         2'b01, 6'd2});
    tbl.push_back('{"wr_rsv3",   2'b01, 5'd3, 5'd0, 32'd5, 32'd0,                 5'd3, 5'd4,  1'b1, 5'd3,  1'b0, 32'd5,         32'd0,         2'b10, 6'd2});
    tbl.push_back('{"x3_busy",   2'b00, 5'd0, 5'd0, 32'd0, 32'd0,                 5'd3, 5'd4,  1'b0, 5'd0,  1'b0, 32'd5,         32'd0,         2'b11, 6'd2});
    tbl.push_back('{"wr4",       2'b10, 5'd0, 5'd4, 32'd0, 32'h44,                5'd4, 5'd3,  1'b0, 5'd0,  1'b0, 32'h44,        32'd5,         2'b10, 6'd1});
    tbl.push_back('{"wr3",       2'b01, 5'd3, 5'd0, 32'd6, 32'd0,                 5'd3, 5'd4,  1'b0, 5'd0,  1'b0, 32'd6,         32'h44,        2'b00, 6'd0});
    tbl.push_back('{"rsv1",      2'b00, 5'd0, 5'd0, 32'd0, 32'd0,                 5'd1, 5'd3,  1'b1, 5'd1,  1'b0, 32'd0,         32'd6,         2'b00, 6'd1});
    tbl.push_back('{"rsv2",      2'b00, 5'd0, 5'd0, 32'd0, 32'd0,                 5'd1, 5'd2,  1'b1, 5'd2,  1'b0, 32'd0,         32'd0,         2'b01, 6'd2});
    tbl.push_back('{"rsv9",      2'b00, 5'd0, 5'd0, 32'd0, 32'd0,                 5'd2, 5'd9,  1'b1, 5'd9,  1'b0, 32'd0,         32'd0,         2'b01, 6'd3});
    tbl.push_back('{"flush",     2'b01, 5'd2, 5'd0, 32'hA5, 32'd0,                5'd2, 5'd9,  1'b1, 5'd10, 1'b1, 32'hA5,        32'd0,         2'b10, 6'd0});
    tbl.push_back('{"flush_nxt", 2'b00, 5'd0, 5'd0, 32'd0, 32'd0,                 5'd2, 5'd10, 1'b0, 5'd0,  1'b0, 32'hA5,        32'd0,         2'b00, 6'd0});

    foreach (tbl[i]) begin
      WR_EN    = tbl[i].we;
      WR_ADDR  = {tbl[i].wa1, tbl[i].wa0};
      WR_DATA  = {tbl[i].wd1, tbl[i].wd0};
      RD_ADDR  = {tbl[i].ra1, tbl[i].ra0};
      RSV_EN   = tbl[i].rsv;
      RSV_ADDR = tbl[i].rsva;
      FLUSH    = tbl[i].fl;
      #1;
      chk({tbl[i].nm, "_rd0"}, RD_DATA[31:0], tbl[i].e_rd0);
      chk({tbl[i].nm, "_rd1"}, RD_DATA[63:32], tbl[i].e_rd1);
      chk({tbl[i].nm, "_busy"}, {30'd0, RD_BUSY}, {30'd0, tbl[i].e_bsy});
      @(posedge CLK);
      model_edge();
      #1;
      chk({tbl[i].nm, "_cnt"}, {26'd0, BUSY_CNT}, {26'd0, tbl[i].e_cnt});
    end

    // Random traffic over a small address window to force collisions.
    for (int n = 0; n < 300; n++) begin
      WR_EN    = 2'($urandom_range(0, 3));
      WR_ADDR  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      WR_DATA  = {32'($urandom), 32'($urandom)};
      RD_ADDR  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      RSV_EN   = ($urandom_range(0, 9) < 4);
      RSV_ADDR = 5'($urandom_range(0, 7));
      FLUSH    = ($urandom_range(0, 19) == 0);
      #1;
      check_reads("rnd");
      @(posedge CLK);
      model_edge();
      #1;
      chk("rnd_cnt", {26'd0, BUSY_CNT}, 32'(model_cnt()));
    end

    // Async reset landing between edges while a write is pending.
    idle();
    WR_EN = 2'b01; WR_ADDR = {5'd0, 5'd5}; WR_DATA = {32'd0, 32'hAAAA_AAAA};
    RSV_EN = 1'b1; RSV_ADDR = 5'd6;
    RD_ADDR = {5'd6, 5'd5};
    @(posedge CLK); model_edge(); #1;
    RSV_EN = 1'b0;
    WR_DATA = {32'd0, 32'hBBBB_BBBB};
    #1;
    chk("mid_bypass", RD_DATA[31:0], 32'hBBBB_BBBB);
    chk("mid_pre_busy6", {31'd0, RD_BUSY[1]}, 32'd1);
    #2;
    RESET = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_rd0", RD_DATA[31:0], 32'd0);
    chk("mid_rst_busy", {30'd0, RD_BUSY}, 32'd0);
    chk("mid_rst_cnt", {26'd0, BUSY_CNT}, 32'd0);
    @(posedge CLK); #1;
    chk("mid_edge_rd0", RD_DATA[31:0], 32'd0);
    idle();
    RESET = 1'b1;
    #1;
    chk("mid_rel_rd0", RD_DATA[31:0], 32'd0);
    @(posedge CLK); #1;
    chk("mid_rel_rd0_edge", RD_DATA[31:0], 32'd0);
    chk("mid_rel_cnt", {26'd0, BUSY_CNT}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog: the bench must always end on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
